// File: rtl/mmio_timer_if.sv
// Data-memory bus bundle between the CPU (master) and the mmio_timer responder (slave).
// The CPU drives ce/we/addr/sel/data_i. The responder returns data_o combinationally.
interface mmio_timer_if;
  logic        ce;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  sel;
  logic [31:0] data_i;
  logic [31:0] data_o;

  modport master (output ce, we, addr, sel, data_i, input data_o);
  modport slave  (input ce, we, addr, sel, data_i, output data_o);
endinterface

// File: rtl/mmio_timer.sv
// mmio_timer: memory-mapped timer on the CPU data-memory bus.
//   Window: 16 bytes at BASE_ADDR (decoded on addr[31:4]).
//   Registers: 0x0 CTRL, 0x4 COUNT, 0x8 COMPARE, 0xC STATUS.
//   The timer supports one-shot and periodic compare. int_o = MATCH & IE.
// Optional feature: define MMIO_TIMER_PRESCALE_EN to implement CTRL[15:8] PRESCALE.
//   With PRESCALE implemented, one tick occurs every PRESCALE+1 RUN cycles.
//   Without it, CTRL[15:8] reads as zero and one tick occurs every RUN cycle.
module mmio_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        rst,
  mmio_timer_if.slave bus,
  output logic        int_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_COUNT   = 2'd1;
  localparam logic [1:0] REG_COMPARE = 2'd2;
  localparam logic [1:0] REG_STATUS  = 2'd3;

  state_t      state_r;
  state_t      state_nxt_s;
  logic        periodic_r;
  logic        ie_r;
  logic        match_r;
  logic [31:0] count_r;
  logic [31:0] compare_r;

  logic        hit_s;
  logic        rd_s;
  logic        wr_any_s;
  logic [1:0]  reg_s;
  logic        wr_ctrl_s;
  logic        wr_count_s;
  logic        wr_compare_s;
  logic        wr_status_s;
  logic        en_wr_s;
  logic        tick_s;
  logic        match_hit_s;
  logic        oneshot_done_s;
  logic [31:0] tick_count_s;
  logic [31:0] count_nxt_s;
  logic [7:0]  prescale_rd_s;
  logic [31:0] rd_data_s;
  logic        unused_addr_s;

  // Replace only the byte lanes that are enabled in the write strobe.
  function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  lanes);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = lanes[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    end
    return res;
  endfunction

  assign hit_s         = bus.ce && (bus.addr[31:4] == BASE_ADDR[31:4]);
  assign reg_s         = bus.addr[3:2];
  assign rd_s          = hit_s && !bus.we;
  // With sel == 0000, a write touches nothing, so it is not treated as a write at all.
  assign wr_any_s      = hit_s && bus.we && (bus.sel != 4'b0000);
  assign wr_ctrl_s     = wr_any_s && (reg_s == REG_CTRL);
  assign wr_count_s    = wr_any_s && (reg_s == REG_COUNT);
  assign wr_compare_s  = wr_any_s && (reg_s == REG_COMPARE);
  assign wr_status_s   = wr_any_s && (reg_s == REG_STATUS);
  assign en_wr_s       = wr_ctrl_s && bus.sel[0];
  assign unused_addr_s = &{1'b0, bus.addr[1:0]};

`ifdef MMIO_TIMER_PRESCALE_EN
  logic [7:0] prescale_r;
  logic [7:0] presc_cnt_r;

  assign tick_s        = (state_r == ST_RUN) && (presc_cnt_r == prescale_r);
  assign prescale_rd_s = prescale_r;

  // Prescaler phase: restarts on any CTRL write, on each tick and whenever not running.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_cnt_r <= 8'd0;
    end else if (wr_ctrl_s || tick_s || (state_nxt_s != ST_RUN)) begin
      presc_cnt_r <= 8'd0;
    end else begin
      presc_cnt_r <= presc_cnt_r + 8'd1;
    end
  end

  // PRESCALE field lives in CTRL byte lane 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescale_r <= 8'd0;
    end else if (wr_ctrl_s && bus.sel[1]) begin
      prescale_r <= bus.data_i[15:8];
    end
  end
`else
  assign tick_s        = (state_r == ST_RUN);
  assign prescale_rd_s = 8'd0;
`endif

  assign match_hit_s    = tick_s && (count_r == compare_r);
  assign oneshot_done_s = match_hit_s && !periodic_r;

  // Next state: a one-shot match has priority over any EN write in the same cycle.
  always_comb begin
    state_nxt_s = ST_IDLE;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (en_wr_s) begin
          state_nxt_s = bus.data_i[0] ? ST_RUN : ST_IDLE;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_RUN: begin
        if (oneshot_done_s) begin
          state_nxt_s = ST_DONE;
        end else if (en_wr_s && !bus.data_i[0]) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Counter next value: tick result first, then bus-written lanes override it.
  always_comb begin
    tick_count_s = count_r;
    count_nxt_s  = count_r;
    if (tick_s) begin
      if (match_hit_s) begin
        tick_count_s = periodic_r ? 32'd0 : count_r;
      end else begin
        tick_count_s = count_r + 32'd1;
      end
    end else begin
      tick_count_s = count_r;
    end
    if (wr_count_s) begin
      count_nxt_s = lane_merge(tick_count_s, bus.data_i, bus.sel);
    end else begin
      count_nxt_s = tick_count_s;
    end
  end

  // COUNT register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= 32'd0;
    end else begin
      count_r <= count_nxt_s;
    end
  end

  // COMPARE register, byte-lane writable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      compare_r <= 32'd0;
    end else if (wr_compare_s) begin
      compare_r <= lane_merge(compare_r, bus.data_i, bus.sel);
    end
  end

  // CTRL mode bits (EN is represented by the RUN state itself).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      periodic_r <= 1'b0;
      ie_r       <= 1'b0;
    end else if (en_wr_s) begin
      periodic_r <= bus.data_i[1];
      ie_r       <= bus.data_i[2];
    end
  end

  // MATCH flag: hardware set wins over a W1C clear in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match_r <= 1'b0;
    end else if (match_hit_s) begin
      match_r <= 1'b1;
    end else if (wr_status_s && bus.sel[0] && bus.data_i[0]) begin
      match_r <= 1'b0;
    end
  end

  // Zero-latency read mux; returns 0 outside read hits.
  always_comb begin
    rd_data_s = 32'h0000_0000;
    if (rd_s) begin
      case (reg_s)
        REG_CTRL:    rd_data_s = {16'h0000, prescale_rd_s, 5'b00000, ie_r, periodic_r,
                                  (state_r == ST_RUN)};
        REG_COUNT:   rd_data_s = count_r;
        REG_COMPARE: rd_data_s = compare_r;
        REG_STATUS:  rd_data_s = {29'h0000_0000, state_r, match_r};
        default:     rd_data_s = 32'h0000_0000;
      endcase
    end else begin
      rd_data_s = 32'h0000_0000;
    end
  end

  assign bus.data_o = rd_data_s;
  assign int_o      = match_r & ie_r;

endmodule

// File: tb/tb_mmio_timer.sv
// Self-checking bench for mmio_timer.
// A behavioural model tracks the register file and the tick schedule as a countdown.
// A compare process checks data_o and int_o against the model on every falling edge.
// Directed sequences with literal expectations pin the model. Randomized bus traffic follows.
module tb_mmio_timer;
  localparam logic [31:0] BASE = 32'h1000_0000;
`ifdef MMIO_TIMER_PRESCALE_EN
  localparam bit PRESC_ON = 1'b1;
`else
  localparam bit PRESC_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic int_o;
  int   n_checks = 0;
  int   n_fail   = 0;

  mmio_timer_if bus();

  mmio_timer #(.BASE_ADDR(BASE)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus.slave),
    .int_o (int_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  st;        // 0 idle, 1 run, 2 done
    logic        per;
    logic        ie;
    logic [7:0]  presc;
    logic [7:0]  wait_cnt;  // RUN cycles left before the next tick
    logic [31:0] count;
    logic [31:0] compare;
    logic        match;
  } model_t;

  model_t m;

  function automatic logic [31:0] lane_mask(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

  function automatic model_t model_next(input model_t c, input logic ce, input logic we,
                                        input logic [31:0] a, input logic [3:0] s,
                                        input logic [31:0] d);
    model_t      n;
    bit          wr;
    bit          tick;
    bit          fire;
    logic [31:0] mk;
    n    = c;
    wr   = ce && we && (a[31:4] == BASE[31:4]) && (s != 4'h0);
    mk   = lane_mask(s);
    tick = (c.st == 2'd1) && (c.wait_cnt == 8'd0);
    fire = tick && (c.count == c.compare);
    if (tick) begin
      n.wait_cnt = c.presc;
      if (!fire)      n.count = c.count + 32'd1;
      else if (c.per) n.count = 32'd0;
      if (fire) n.match = 1'b1;
      if (fire && !c.per) n.st = 2'd2;
    end else if (c.st == 2'd1) begin
      n.wait_cnt = c.wait_cnt - 8'd1;
    end
    if (wr) begin
      case (a[3:2])
        2'd0: begin
          if (PRESC_ON && s[1]) n.presc = d[15:8];
          if (s[0]) begin
            n.ie  = d[2];
            n.per = d[1];
            if (!(fire && !c.per)) n.st = d[0] ? 2'd1 : 2'd0;
          end
          n.wait_cnt = n.presc;
        end
        2'd1: n.count   = (n.count & ~mk) | (d & mk);
        2'd2: n.compare = (c.compare & ~mk) | (d & mk);
        default: if (s[0] && d[0] && !fire) n.match = 1'b0;
      endcase
    end
    return n;
  endfunction

  function automatic logic [31:0] exp_read(input model_t c, input logic ce, input logic we,
                                           input logic [31:0] a);
    logic [31:0] v;
    v = 32'h0;
    if (ce && !we && (a[31:4] == BASE[31:4])) begin
      case (a[3:2])
        2'd0:    v = {16'h0, c.presc, 5'h0, c.ie, c.per, (c.st == 2'd1)};
        2'd1:    v = c.count;
        2'd2:    v = c.compare;
        default: v = {29'h0, c.st, c.match};
      endcase
    end
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model advances on the same edge as the DUT.
  always @(posedge clk or posedge rst) begin
    if (rst) m <= '0;
    else     m <= model_next(m, bus.ce, bus.we, bus.addr, bus.sel, bus.data_i);
  end

  // Compare process: outputs are checked against the model on every falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      chk("data_o", bus.data_o, exp_read(m, bus.ce, bus.we, bus.addr));
      chk("int_o", {31'h0, int_o}, {31'h0, m.match & m.ie});
    end
  end

  task automatic drive(input logic ce, input logic we, input logic [31:0] a,
                       input logic [3:0] s, input logic [31:0] d);
    @(posedge clk);
    #2;
    bus.ce = ce; bus.we = we; bus.addr = a; bus.sel = s; bus.data_i = d;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
  endtask

  task automatic wr(input logic [31:0] off, input logic [3:0] s, input logic [31:0] d);
    drive(1'b1, 1'b1, BASE + off, s, d);
  endtask

  task automatic rd_chk(input string nm, input logic [31:0] off, input logic [31:0] exp);
    drive(1'b1, 1'b0, BASE + off, 4'hF, 32'h0);
    #1;
    chk(nm, bus.data_o, exp);
  endtask

  logic [31:0] per_cnt[6] = '{32'd0, 32'd1, 32'd2, 32'd0, 32'd1, 32'd2};
  logic [31:0] psc_on[9]  = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd1, 32'd1, 32'd1, 32'd1, 32'd0};
  logic [31:0] psc_off[9] = '{32'd0, 32'd1, 32'd0, 32'd1, 32'd0, 32'd1, 32'd0, 32'd1, 32'd0};

  initial begin
    bus.ce = 1'b0; bus.we = 1'b0; bus.addr = 32'h0; bus.sel = 4'h0; bus.data_i = 32'h0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1 chk("reset_int", {31'h0, int_o}, 32'h0);
    #21 rst = 1'b0;

    // Reset values.
    rd_chk("rst_ctrl", 32'h0, 32'h0);
    rd_chk("rst_count", 32'h4, 32'h0);
    rd_chk("rst_compare", 32'h8, 32'h0);
    rd_chk("rst_status", 32'hC, 32'h0);

    // One-shot: COMPARE=3, CTRL=EN|IE.
    wr(32'h8, 4'hF, 32'd3);
    wr(32'h4, 4'hF, 32'd0);
    wr(32'h0, 4'hF, 32'h5);
    rd_chk("os_cnt0", 32'h4, 32'd0);
    rd_chk("os_cnt1", 32'h4, 32'd1);
    rd_chk("os_cnt2", 32'h4, 32'd2);
    rd_chk("os_cnt3", 32'h4, 32'd3);
    rd_chk("os_status", 32'hC, 32'h5);
    chk("os_int", {31'h0, int_o}, 32'h1);
    rd_chk("os_ctrl", 32'h0, 32'h4);
    rd_chk("os_hold", 32'h4, 32'd3);
    chk("os_model_count", m.count, 32'd3);
    wr(32'hC, 4'hF, 32'h1);
    wr(32'h0, 4'hF, 32'h0);

    // One-shot match coinciding with an EN=1 write ends in DONE with EN=0.
    wr(32'h8, 4'hF, 32'd1);
    wr(32'h4, 4'hF, 32'd0);
    wr(32'h0, 4'hF, 32'h1);
    idle();
    wr(32'h0, 4'hF, 32'h1);
    rd_chk("col_status", 32'hC, 32'h5);
    rd_chk("col_ctrl", 32'h0, 32'h0);
    wr(32'hC, 4'hF, 32'h1);
    wr(32'h0, 4'hF, 32'h0);

    // Periodic: COMPARE=2, CTRL=EN|PERIODIC. Matches land 3, 6, 9 edges after enable.
    wr(32'h8, 4'hF, 32'd2);
    wr(32'h4, 4'hF, 32'd0);
    wr(32'h0, 4'hF, 32'h3);
    for (int j = 0; j < 6; j++) rd_chk("per_cnt", 32'h4, per_cnt[j]);
    wr(32'hC, 4'hF, 32'h1);
    rd_chk("per_w1c", 32'hC, 32'h2);
    wr(32'hC, 4'hF, 32'h1);
    rd_chk("per_w1c_collide", 32'hC, 32'h3);
    wr(32'h0, 4'hF, 32'h0);
    wr(32'hC, 4'hF, 32'h1);

    // Byte lanes and out-of-window accesses.
    wr(32'h4, 4'hF, 32'h0);
    wr(32'h4, 4'b0100, 32'hAABB_CCDD);
    rd_chk("lane_write", 32'h4, 32'h00BB_0000);
    wr(32'h4, 4'b0000, 32'hFFFF_FFFF);
    rd_chk("lane_sel0", 32'h4, 32'h00BB_0000);
    drive(1'b1, 1'b0, 32'h2000_0004, 4'hF, 32'h0);
    #1 chk("out_of_window_rd", bus.data_o, 32'h0);
    drive(1'b1, 1'b1, 32'h1000_0014, 4'hF, 32'h1234);
    rd_chk("out_of_window_wr", 32'h4, 32'h00BB_0000);

    // Wrap without flag, then a bus write on a tick edge wins.
    wr(32'h8, 4'hF, 32'd5);
    wr(32'h4, 4'hF, 32'hFFFF_FFFF);
    wr(32'h0, 4'hF, 32'h1);
    rd_chk("wrap_pre", 32'h4, 32'hFFFF_FFFF);
    rd_chk("wrap_zero", 32'h4, 32'h0);
    rd_chk("wrap_nomatch", 32'hC, 32'h2);
    wr(32'h4, 4'hF, 32'd10);
    rd_chk("tick_write", 32'h4, 32'd10);
    wr(32'h0, 4'hF, 32'h0);

    // Prescale: PRESCALE=3, COMPARE=1, periodic.
    wr(32'h0, 4'hF, 32'h0000_0302);
    rd_chk("psc_ctrl", 32'h0, PRESC_ON ? 32'h0000_0302 : 32'h0000_0002);
    wr(32'h8, 4'hF, 32'd1);
    wr(32'h4, 4'hF, 32'd0);
    wr(32'h0, 4'hF, 32'h0000_0303);
    for (int j = 0; j < 9; j++) rd_chk("psc_cnt", 32'h4, PRESC_ON ? psc_on[j] : psc_off[j]);
    wr(32'h0, 4'hF, 32'h0);
    wr(32'hC, 4'hF, 32'h1);

    // Randomized traffic checked by the compare process.
    for (int i = 0; i < 3000; i++) begin
      int          op;
      logic [1:0]  r;
      logic [3:0]  s;
      logic [31:0] d;
      op = $urandom_range(0, 9);
      r  = 2'($urandom_range(0, 3));
      s  = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
      d  = $urandom;
      case (op)
        0, 1, 2: idle();
        3, 4:    drive(1'b1, 1'b0, BASE + {28'h0, r, 2'b00}, s, d);
        5:       drive(1'b1, $urandom_range(0, 1) == 1, BASE ^ (32'h1 << $urandom_range(4, 31)),
                       s, d);
        default: begin
          if (r == 2'd0) d[15:8] = 8'($urandom_range(0, 2));
          if (r == 2'd1) d = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFE : 32'($urandom_range(0, 8));
          if (r == 2'd2) d = 32'($urandom_range(0, 6));
          wr({28'h0, r, 2'b00}, s, d);
        end
      endcase
    end

    // Asynchronous reset mid-run with MATCH=1 and IE=1.
    wr(32'h0, 4'hF, 32'h0);
    wr(32'h8, 4'hF, 32'd0);
    wr(32'h4, 4'hF, 32'd0);
    wr(32'h0, 4'hF, 32'h7);
    idle();
    idle();
    #1 chk("pre_rst_int", {31'h0, int_o}, 32'h1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1 chk("async_rst_int", {31'h0, int_o}, 32'h0);
    @(posedge clk);
    #3 rst = 1'b0;
    rd_chk("post_rst_ctrl", 32'h0, 32'h0);
    rd_chk("post_rst_count", 32'h4, 32'h0);
    rd_chk("post_rst_compare", 32'h8, 32'h0);
    rd_chk("post_rst_status", 32'hC, 32'h0);
    idle();
    idle();
    rd_chk("post_rst_stays", 32'h4, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mmio_timer.md
# mmio_timer

Memory-mapped timer that acts as a responder on the CPU data-memory bus (ce/we/addr/sel/data), sitting beside the data RAM in the SoC address map. It decodes a 16-byte window, supports byte-lane writes and same-cycle combinational reads, and runs a free-running counter with compare match, one-shot or periodic mode, and a level interrupt to the CPU.

## Interface
- BASE_ADDR, 32'h1000_0000, window base; decoded on addr[31:4] (bits [3:0] of BASE_ADDR ignored)
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- ce  in  1  bus access enable from CPU
- we  in  1  1 = write, 0 = read (valid when ce)
- addr  in  32  byte address; hit = ce & (addr[31:4] == BASE_ADDR[31:4]); register = addr[3:2]
- sel  in  4  byte lanes; sel[i] enables data_i[8i+7:8i]
- data_i  in  32  write data
- data_o  out  32  read data, combinational
- int_o  out  1  timer interrupt, level, active-high

## Operation
- Registers: 0 CTRL, 1 COUNT, 2 COMPARE, 3 STATUS (offsets 0x0/0x4/0x8/0xC).
- CTRL: [0] EN, [1] PERIODIC, [2] IE, [15:8] PRESCALE (macro only); other bits read 0, writes ignored.
- STATUS: [0] MATCH (write-1-to-clear), [2:1] state (00 IDLE, 01 RUN, 10 DONE); read-only except MATCH clear.
- Writes: on rising edge when hit & we; only lanes with sel[i]=1 update; sel=0000 writes nothing.
- Reads: data_o = selected register when hit & ~we, else 32'h0. No side effects on read.
- FSM: IDLE -> RUN when EN written 1. RUN -> IDLE when EN written 0. RUN -> DONE on match with PERIODIC=0 (hardware clears EN). DONE -> RUN when EN written 1; DONE -> IDLE when EN written 0.
- Tick: in RUN, one tick every PRESCALE+1 cycles (every cycle without macro). Prescaler counter clears on leaving RUN and on any CTRL write.
- At a tick: if COUNT == COMPARE -> MATCH<=1; PERIODIC=1: COUNT<=0, stay RUN; PERIODIC=0: COUNT holds, go DONE. Else COUNT<=COUNT+1 (mod 2^32, 0xFFFF_FFFF wraps to 0, no flag).
- Period in periodic mode = (COMPARE+1)*(PRESCALE+1) cycles.
- int_o = MATCH & IE (from registers, glitch-free).
- Simultaneous events: bus write to COUNT beats tick increment/reload for written lanes (unwritten lanes take tick result); MATCH set beats W1C clear in the same cycle; hardware EN clear on one-shot match beats EN=1 write in the same cycle (state ends DONE, EN=0).

## Timing
- Reset (async, immediate, no clock needed): CTRL=0, COUNT=0, COMPARE=0, MATCH=0, state IDLE, prescaler=0; int_o=0; data_o=0 (combinational, follows bus).
- Read latency 0: data_o valid same cycle as hit & ~we, reflects register state before the edge.
- Write EN=1 at edge k (PRESCALE=P): first tick at edge k+P+1.
- MATCH/int_o visible the cycle after the matching tick edge.
- rst asserted mid-count: counter, state, int_o clear immediately; resume only after new EN write.

## Configuration
- MMIO_TIMER_PRESCALE_EN defined: CTRL[15:8] PRESCALE implemented, readable/writable, divides tick rate by PRESCALE+1.
- Not defined: no prescaler logic; CTRL[15:8] read 0, writes ignored; tick every RUN cycle.

## Test plan
- Reset: assert rst mid-run with MATCH=1, IE=1 -> int_o falls without clock edge; all registers read 0 after release.
- One-shot: COMPARE=3, CTRL=0x5 (EN,IE) -> COUNT 1,2,3 on edges k+1..k+3, MATCH and int_o high after k+4, STATUS state=DONE, CTRL reads 0x4, COUNT stays 3.
- Periodic: COMPARE=2, CTRL=0x3 -> MATCH every 3 cycles, COUNT sequence 1,2,0,1,2,0; W1C STATUS=1 clears MATCH; W1C on a match edge leaves MATCH=1.
- Byte lanes: COUNT=0, write 0xAABBCCDD with sel=0100 while IDLE -> COUNT reads 0x00BB0000; read with addr outside window -> data_o=0.
- Wrap/collision: COUNT=0xFFFF_FFFF, COMPARE=5, EN -> COUNT=0 next edge, no MATCH; write COUNT=10 on a tick edge -> COUNT reads 10.
- Prescale (macro on): PRESCALE=3, COMPARE=1, periodic -> MATCH every 8 cycles; macro off: same write reads CTRL[15:8]=0, MATCH every 2 cycles.
